// File: rtl/des_sbox_sequencer_if.sv
// Handshake bundle between the DES round controller (master) and the
// S-box sequencer (slave): one 48-bit word in, one 32-bit result out.
interface des_sbox_sequencer_if;
  logic        wInValid;
  logic        wInReady;
  logic [0:47] wInData;
  logic        wOutValid;
  logic        wOutReady;
  logic [0:31] wOutData;
  logic        wBusy;

  modport master (
    output wInValid, wInData, wOutReady,
    input  wInReady, wOutValid, wOutData, wBusy
  );

  modport slave (
    input  wInValid, wInData, wOutReady,
    output wInReady, wOutValid, wOutData, wBusy
  );
endinterface

// File: rtl/des_sbox_sequencer.sv
// DES S-box substitution: one fixed 6-to-4 lookup per box (des_sbox) and a
// sequencer that walks the eight boxes NUM_LANES at a time and assembles the
// 32-bit result for the P-permutation stage.

module des_sbox #(
  parameter int BOX = 1
) (
  input  logic [5:0] chunk,
  output logic [3:0] dout
);
  // Each table is 64 nibbles, row-major (row*16 + col), entry 0 in the top nibble.
  function automatic logic [255:0] box_table(input int b);
    case (b)
      1: return 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      2: return 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3: return 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      4: return 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      5: return 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      6: return 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      7: return 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      default: return 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    endcase
  endfunction

  localparam logic [255:0] TABLE = box_table(BOX);

  logic [5:0] idx;

  // Row is the outer bit pair {b0,b5}, column the inner bits b1..b4.
  assign idx  = {chunk[5], chunk[0], chunk[4:1]};
  // Entry k lives at nibble (63-k), and 63-k is simply ~k for a 6-bit index.
  assign dout = TABLE[{~idx, 2'b00} +: 4];
endmodule

module des_sbox_sequencer #(
  parameter int NUM_LANES = 1
) (
  input  logic                       wClk,
  input  logic                       wResetN,
  des_sbox_sequencer_if.slave        bus
);
  localparam int NUM_GROUPS = 8 / NUM_LANES;
  localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4 && NUM_LANES != 8) begin : g_bad_lanes
    $error("des_sbox_sequencer: NUM_LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [0:47]      in_q;
  logic [0:31]      result_q, result_d;
  logic [CNT_W-1:0] grp_q;
  logic [3:0]       sbox_out [8];
  logic             last_group;

  assign last_group = (grp_q == LAST_GROUP);

  // All eight boxes see their captured chunk every cycle; the group counter
  // decides which of their outputs are written into the result.
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    des_sbox #(.BOX(j + 1)) u_sbox (
      .chunk (in_q[6*j +: 6]),
      .dout  (sbox_out[j])
    );
  end

  // State register.
  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge wClk) begin
    if (!wResetN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode: accept in IDLE, walk the groups in RUN, wait for the consumer in DONE.
  // NOTE: state_d takes a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.wInValid) state_d = RUN;
      RUN:     if (last_group)   state_d = DONE;
      DONE:    if (bus.wOutReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state and the result register only, never from inputs.
  always_comb begin
    bus.wInReady  = (state_q == IDLE);
    bus.wOutValid = (state_q == DONE);
    bus.wBusy     = (state_q != IDLE);
    bus.wOutData  = result_q;
  end

  // Merge the current group's S-box nibbles into the running result.
  always_comb begin
    result_d = result_q;
    for (int j = 0; j < 8; j++) begin
      if ((j / NUM_LANES) == int'(grp_q)) result_d[4*j +: 4] = sbox_out[j];
    end
  end

  // Input capture; only read during RUN, which always follows a load.
  // NOTE: this data register is deliberately left without reset.
  always_ff @(posedge wClk) begin
    if (state_q == IDLE && bus.wInValid) in_q <= bus.wInData;
  end

  // Group counter and result register; cleared on reset and on each new word.
  always_ff @(posedge wClk) begin
    if (!wResetN) begin
      grp_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wInValid) begin
            grp_q    <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          grp_q    <= grp_q + CNT_W'(1);
          result_q <= result_d;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed and random checks of des_sbox_sequencer for all lane counts.
module tb_des_sbox_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  des_sbox_sequencer_if if1 ();
  des_sbox_sequencer_if if2 ();
  des_sbox_sequencer_if if4 ();
  des_sbox_sequencer_if if8 ();

  des_sbox_sequencer #(.NUM_LANES(1)) u_dut1 (.wClk(clk), .wResetN(rst_n), .bus(if1.slave));
  des_sbox_sequencer #(.NUM_LANES(2)) u_dut2 (.wClk(clk), .wResetN(rst_n), .bus(if2.slave));
  des_sbox_sequencer #(.NUM_LANES(4)) u_dut4 (.wClk(clk), .wResetN(rst_n), .bus(if4.slave));
  des_sbox_sequencer #(.NUM_LANES(8)) u_dut8 (.wClk(clk), .wResetN(rst_n), .bus(if8.slave));

  // Standard DES S-box tables, row-major, decimal.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  localparam logic [0:31] ZERO_RES = 32'hEFA72C4D;
  localparam logic [0:31] ONES_RES = 32'hD9CE3DCB;
  localparam logic [0:47] ALL_ONES = 48'hFFFFFFFFFFFF;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:31] sbox_model(input logic [0:47] din);
    logic [0:31] res;
    int b, row, col, v;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      b   = 6 * i;
      row = 2 * int'(din[b]) + int'(din[b+5]);
      col = 8 * int'(din[b+1]) + 4 * int'(din[b+2]) + 2 * int'(din[b+3]) + int'(din[b+4]);
      v   = SBOX[i][16*row + col];
      for (int k = 0; k < 4; k++) res[4*i + k] = v[3-k];
    end
    return res;
  endfunction

  // One word through the NUM_LANES=1 instance with the consumer always ready.
  task automatic send_lane1(input logic [0:47] d, input logic [0:31] exp, input int exp_lat, input string tag);
    int lat;
    if1.wInData   = d;
    if1.wInValid  = 1'b1;
    if1.wOutReady = 1'b1;
    check({tag, "_ready_pre"}, 64'(if1.wInReady), 64'd1);
    tick();
    if1.wInValid = 1'b0;
    check({tag, "_ready_run"}, 64'(if1.wInReady), 64'd0);
    check({tag, "_busy_run"}, 64'(if1.wBusy), 64'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (if1.wOutValid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(if1.wOutData), 64'(exp));
    tick();
    check({tag, "_valid_after"}, 64'(if1.wOutValid), 64'd0);
    check({tag, "_ready_after"}, 64'(if1.wInReady), 64'd1);
    check({tag, "_data_kept"}, 64'(if1.wOutData), 64'(exp));
  endtask

  task automatic all_lanes_ones();
    int lat1, lat2, lat4, lat8;
    logic [0:31] d1, d2, d4, d8;
    lat1 = 0; lat2 = 0; lat4 = 0; lat8 = 0;
    d1 = '0; d2 = '0; d4 = '0; d8 = '0;
    if1.wInData = ALL_ONES; if2.wInData = ALL_ONES; if4.wInData = ALL_ONES; if8.wInData = ALL_ONES;
    if1.wOutReady = 1'b1; if2.wOutReady = 1'b1; if4.wOutReady = 1'b1; if8.wOutReady = 1'b1;
    if1.wInValid = 1'b1; if2.wInValid = 1'b1; if4.wInValid = 1'b1; if8.wInValid = 1'b1;
    tick();
    if1.wInValid = 1'b0; if2.wInValid = 1'b0; if4.wInValid = 1'b0; if8.wInValid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (if1.wOutValid && lat1 == 0) begin lat1 = k; d1 = if1.wOutData; end
      if (if2.wOutValid && lat2 == 0) begin lat2 = k; d2 = if2.wOutData; end
      if (if4.wOutValid && lat4 == 0) begin lat4 = k; d4 = if4.wOutData; end
      if (if8.wOutValid && lat8 == 0) begin lat8 = k; d8 = if8.wOutData; end
    end
    check("ones_l1_latency", 64'(lat1), 64'd8);
    check("ones_l2_latency", 64'(lat2), 64'd4);
    check("ones_l4_latency", 64'(lat4), 64'd2);
    check("ones_l8_latency", 64'(lat8), 64'd1);
    check("ones_l1_data", 64'(d1), 64'(ONES_RES));
    check("ones_l2_data", 64'(d2), 64'(ONES_RES));
    check("ones_l4_data", 64'(d4), 64'(ONES_RES));
    check("ones_l8_data", 64'(d8), 64'(ONES_RES));
  endtask

  task automatic backpressure();
    logic [63:0] r;
    logic seen;
    seen = 1'b0;
    if1.wOutReady = 1'b0;
    if1.wInData   = '0;
    if1.wInValid  = 1'b1;
    tick();
    if1.wInValid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = if1.wOutValid;
    end
    check("bp_reached_done", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      r = {$urandom(), $urandom()};
      if1.wInData  = r[47:0];
      if1.wInValid = ~if1.wInValid;
      tick();
      check("bp_data_stable", 64'(if1.wOutData), 64'(ZERO_RES));
      check("bp_ready_low", 64'(if1.wInReady), 64'd0);
      check("bp_valid_held", 64'(if1.wOutValid), 64'd1);
    end
    if1.wInValid  = 1'b0;
    if1.wOutReady = 1'b1;
    tick();
    check("bp_release_valid", 64'(if1.wOutValid), 64'd0);
    check("bp_release_ready", 64'(if1.wInReady), 64'd1);
    tick();
    check("bp_no_recapture", 64'(if1.wBusy), 64'd0);
    check("bp_data_kept", 64'(if1.wOutData), 64'(ZERO_RES));
  endtask

  task automatic reset_mid_run();
    logic ov_seen;
    ov_seen = 1'b0;
    if1.wInData   = ALL_ONES;
    if1.wOutReady = 1'b1;
    if1.wInValid  = 1'b1;
    tick();
    if1.wInValid = 1'b0;
    tick();
    ov_seen = ov_seen | if1.wOutValid;
    tick();
    ov_seen = ov_seen | if1.wOutValid;
    rst_n = 1'b0;
    tick();
    ov_seen = ov_seen | if1.wOutValid;
    check("mrst_ready", 64'(if1.wInReady), 64'd1);
    check("mrst_valid", 64'(if1.wOutValid), 64'd0);
    check("mrst_data", 64'(if1.wOutData), 64'd0);
    check("mrst_busy", 64'(if1.wBusy), 64'd0);
    rst_n = 1'b1;
    tick();
    ov_seen = ov_seen | if1.wOutValid;
    check("mrst_never_valid", 64'(ov_seen), 64'd0);
    check("mrst_stays_idle", 64'(if1.wBusy), 64'd0);
    send_lane1('0, ZERO_RES, 8, "after_rst");
  endtask

  task automatic stream_test();
    logic [0:31] exp_q [$];
    logic [63:0] r;
    logic [0:31] od, e;
    logic in_hs, out_hs;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    if1.wInValid  = 1'b0;
    if1.wOutReady = 1'b0;
    while (recv < 1000 && cyc < 40000) begin
      if (!if1.wInValid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        r = {$urandom(), $urandom()};
        if1.wInData  = r[47:0];
        if1.wInValid = 1'b1;
      end
      if1.wOutReady = ($urandom_range(0, 3) != 0);
      in_hs  = if1.wInValid & if1.wInReady;
      out_hs = if1.wOutValid & if1.wOutReady;
      od     = if1.wOutData;
      tick();
      cyc++;
      if (in_hs) begin
        exp_q.push_back(sbox_model(if1.wInData));
        sent++;
        if1.wInValid = 1'b0;
      end
      if (out_hs) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("stream_data", 64'(od), 64'(e));
        recv++;
      end
    end
    check("stream_sent", 64'(sent), 64'd1000);
    check("stream_recv", 64'(recv), 64'd1000);
    check("stream_leftover", 64'(exp_q.size()), 64'd0);
    tick();
    check("stream_end_idle", 64'(if1.wBusy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if1.wInValid = 1'b0; if1.wInData = '0; if1.wOutReady = 1'b1;
    if2.wInValid = 1'b0; if2.wInData = '0; if2.wOutReady = 1'b1;
    if4.wInValid = 1'b0; if4.wInData = '0; if4.wOutReady = 1'b1;
    if8.wInValid = 1'b0; if8.wInData = '0; if8.wOutReady = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'(if1.wInReady), 64'd1);
    check("rst_valid", 64'(if1.wOutValid), 64'd0);
    check("rst_data", 64'(if1.wOutData), 64'd0);
    check("rst_busy", 64'(if1.wBusy), 64'd0);
    check("rst_l8_data", 64'(if8.wOutData), 64'd0);
    rst_n = 1'b1;
    tick();

    send_lane1('0, ZERO_RES, 8, "zero");
    all_lanes_ones();
    backpressure();
    reset_mid_run();
    stream_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
